clock_divide_measure: RTL and testbench
=======================================

Name: clock_divide_measure

Overview:
- Receive-side companion of the 4-channel clock divider. Samples one divided clock on the fast clock and measures its half-period.
- Recovers the 6-bit divide factor that produced it and reports lock once the period is stable.
- Used on-chip for self-test and by downstream logic that needs the active divide setting.

Parameters:
- CNT_W, 8, width of the half-period counter. Must be >= 7.
- LOCK_COUNT, 4, number of consecutive identical in-range half-periods required to assert lock.
- TIMEOUT, 255, counter value at which a missing edge is declared. Must be <= 2^CNT_W-1.

Ports:
- clk  in  1  fast clock; same clock that drives the divider.
- rst  in  1  synchronous, active-high reset.
- sig_in  in  1  divided clock under measurement; treated as asynchronous.
- meas_en  in  1  measurement enable; low forces IDLE.
- factor_out  out  6  recovered divide factor; holds the last locked value.
- half_period  out  CNT_W  last captured edge-to-edge spacing in clk cycles.
- locked  out  1  factor_out is valid and stable.
- valid  out  1  one-cycle pulse on each accepted half-period while locked.
- range_err  out  1  sticky; a captured half-period fell outside 2..65. Cleared by rst or by meas_en low.
- timeout  out  1  one-cycle pulse when no edge has arrived for TIMEOUT cycles.

Behaviour:
- Reset values: factor_out=0, half_period=0, locked=0, valid=0, range_err=0, timeout=0, state=IDLE, cnt=0, match_cnt=0.
- sig_in path:
  - 2-flop synchronizer, then an edge detector on the synchronized value vs. its previous value.
  - Both rising and falling edges count.
  - Fixed 3-cycle input latency; edge spacing is preserved.
- Counter:
  - cnt<=1 on an edge cycle; otherwise increments.
  - Saturates at TIMEOUT.
  - On an edge, captured H = cnt; half_period<=H on the next cycle.
- Arithmetic:
  - Divider half-period is factor+2 cycles, so factor = H-2, truncated to 6 bits.
  - H in range 2..65 is valid.
  - H<2 or H>65 sets range_err, resets match_cnt to 0, and drops lock.
- States:
  - IDLE: cnt and match_cnt held at 0. meas_en=1 -> WAIT_EDGE.
  - WAIT_EDGE: discards the partial period. The first edge restarts cnt -> MEASURE. No H is captured.
  - MEASURE, on each edge:
    - If H==prev_H and H is in range, match_cnt++.
    - Otherwise match_cnt<=1 if H is in range, or 0 if not; prev_H<=H.
    - When match_cnt reaches LOCK_COUNT: factor_out<=H-2, locked<=1 -> LOCKED. Exactly LOCK_COUNT equal spacings are needed, i.e. LOCK_COUNT+1 edges after WAIT_EDGE.
  - LOCKED:
    - Edge with H==prev_H: valid pulse; factor_out unchanged.
    - Edge with mismatched H: locked<=0, no valid pulse, match_cnt<=1 (0 if out of range), prev_H<=H -> MEASURE. factor_out keeps the old value.
- Timeout:
  - In MEASURE or LOCKED, cnt==TIMEOUT with no edge: timeout pulse, locked<=0, match_cnt<=0 -> WAIT_EDGE.
  - A further pulse fires only after a new edge re-arms it.
- meas_en low in any state: next cycle -> IDLE, locked<=0, range_err<=0. factor_out holds.
- Simultaneous edge and cnt==TIMEOUT: the edge wins; H=TIMEOUT is captured, which is out of range.
- rst mid-measurement: all state returns to reset values on the next clk edge. The synchronizer flops also reset to 0.
- All outputs are registered.

Decomposition:
- Package clock_divide_measure_pkg:
  - state enum {IDLE, WAIT_EDGE, MEASURE, LOCKED}
  - FACTOR_W=6
  - H_OFFSET=2
  - H_MAX=65
- Sub-module edge_sync_detect: 2-flop synchronizer plus edge pulse. Ports clk, rst, d_in, edge_out.

Test Plan:
- Divider factor 5 (sig_in toggles every 7 clk), meas_en=1 -> half_period=7. locked rises on the 4th equal spacing after the first edge; factor_out=5; valid pulses every 7 cycles thereafter.
- Factor 0 (toggle every 2 clk) -> factor_out=0 and locked=1. Factor 63 (toggle every 65) -> factor_out=63, range_err=0.
- Locked at 5, switch to factor 20 (spacing 22) -> first 22-cycle edge drops locked with no valid pulse. Relock after 4 spacings of 22; factor_out=20.
- Spacing of 1, then 70 -> range_err=1 (sticky), match_cnt=0, locked stays 0. meas_en pulsed low clears range_err.
- Locked, then sig_in held constant -> timeout pulse 255 cycles after the last edge; locked=0; state WAIT_EDGE. Toggling resumes -> relock after 5 edges.
- rst asserted mid-LOCKED, and separately meas_en low for 1 cycle -> all outputs return to reset values (factor_out holds on meas_en low). Clean relock follows.

Source files
------------

// File: rtl/clock_divide_measure_pkg.sv
// Shared types and constants for the divided-clock half-period measurement block.
// The divider produces a half-period of factor+H_OFFSET fast-clock cycles.
package clock_divide_measure_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_EDGE,
    MEASURE,
    LOCKED
  } state_e;

  localparam int unsigned FACTOR_W = 6;
  localparam int unsigned H_OFFSET = 2;
  localparam int unsigned H_MAX    = 65;

  // A half-period is only meaningful if it maps onto a 6-bit divide factor.
  function automatic logic hInRange(input int unsigned h);
    return (h >= H_OFFSET) && (h <= H_MAX);
  endfunction

endpackage

// File: rtl/clock_divide_measure_edge.sv
// Two-flop synchronizer followed by a registered any-edge detector.
// A change on d_in shows up as a one-cycle edge_out pulse three clocks later.
module edge_sync_detect (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic edge_out
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic edge_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= d_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      edge_q  <= sync2_q ^ prev_q;
    end
  end

  assign edge_out = edge_q;

endmodule

// File: rtl/clock_divide_measure.sv
// Measures the half-period of a divided clock, recovers its divide factor and
// reports lock once LOCK_COUNT consecutive identical in-range spacings are seen.
module clock_divide_measure
  import clock_divide_measure_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sig_in,
  input  logic                meas_en,
  output logic [FACTOR_W-1:0] factor_out,
  output logic [CNT_W-1:0]    half_period,
  output logic                locked,
  output logic                valid,
  output logic                range_err,
  output logic                timeout
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [MW-1:0]    LOCK_MATCH = MW'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);

  logic                edgeDet;
  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [CNT_W-1:0]    prevH_q;
  logic [CNT_W-1:0]    halfPeriod_q;
  logic [MW-1:0]       matchCnt_q;
  logic [MW-1:0]       matchCnt_d;
  logic [FACTOR_W-1:0] factor_q;
  logic                locked_q;
  logic                valid_q;
  logic                rangeErr_q;
  logic                timeout_q;
  logic                hOk;
  logic                hSame;
  logic                atTimeout;

  edge_sync_detect uEdge (
    .clk      (clk),
    .rst      (rst),
    .d_in     (sig_in),
    .edge_out (edgeDet)
  );

  // The captured half-period H is simply cnt_q on an edge cycle.
  always_comb begin
    cnt_d      = cnt_q;
    hOk        = hInRange(32'(cnt_q));
    hSame      = (cnt_q == prevH_q);
    atTimeout  = (cnt_q == TIMEOUT_C);
    matchCnt_d = '0;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (edgeDet) begin
      cnt_d = CNT_W'(1);
    end else if (!atTimeout) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (hOk && hSame) begin
      matchCnt_d = matchCnt_q + 1'b1;
    end else if (hOk) begin
      matchCnt_d = MW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      prevH_q      <= '0;
      halfPeriod_q <= '0;
      matchCnt_q   <= '0;
      factor_q     <= '0;
      locked_q     <= 1'b0;
      valid_q      <= 1'b0;
      rangeErr_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= cnt_d;
      if (!meas_en) begin
        state_q      <= IDLE;
        cnt_q        <= '0;
        matchCnt_q   <= '0;
        halfPeriod_q <= '0;
        locked_q     <= 1'b0;
        rangeErr_q   <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: state_q <= WAIT_EDGE;
          WAIT_EDGE: begin
            if (edgeDet) begin
              state_q <= MEASURE;
            end
          end
          MEASURE, LOCKED: begin
            // An edge always wins over a coincident timeout.
            if (edgeDet) begin
              halfPeriod_q <= cnt_q;
              prevH_q      <= cnt_q;
              if (!hOk) begin
                rangeErr_q <= 1'b1;
              end
              if (state_q == LOCKED && hSame) begin
                valid_q <= 1'b1;
              end else begin
                matchCnt_q <= matchCnt_d;
                if (state_q == MEASURE && matchCnt_d == LOCK_MATCH) begin
                  factor_q <= FACTOR_W'(cnt_q - CNT_W'(H_OFFSET));
                  locked_q <= 1'b1;
                  state_q  <= LOCKED;
                end else begin
                  locked_q <= 1'b0;
                  state_q  <= MEASURE;
                end
              end
            end else if (atTimeout) begin
              timeout_q  <= 1'b1;
              locked_q   <= 1'b0;
              matchCnt_q <= '0;
              state_q    <= WAIT_EDGE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign factor_out  = factor_q;
  assign half_period = halfPeriod_q;
  assign locked      = locked_q;
  assign valid       = valid_q;
  assign range_err   = rangeErr_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_clock_divide_measure.sv
// Randomized scoreboard bench for clock_divide_measure; a timestamp-based reference
// model predicts every valid/timeout pulse and lock/range_err transition.
module tb_clock_divide_measure;

  localparam int CNT_W      = 8;
  localparam int LOCK_COUNT = 4;
  localparam int TIMEOUT    = 255;
  localparam int MAXC       = 65536;

  typedef struct {
    int           cyc;
    logic [5:0]   factor;
    logic [7:0]   hp;
    logic         locked;
    logic         valid;
    logic         rerr;
    logic         tout;
  } ev_t;

  logic             clk;
  logic             rst;
  logic             sig_in;
  logic             meas_en;
  logic [5:0]       factor_out;
  logic [CNT_W-1:0] half_period;
  logic             locked;
  logic             valid;
  logic             range_err;
  logic             timeout;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  bit  togAt [MAXC];
  bit  sigV = 1'b0;
  ev_t expQ [$];

  // Reference model state: phase 0 idle, 1 waiting, 2 measuring, 3 locked.
  int          mPhase = 0;
  int          mLast = 0;
  int          mLockedH = 0;
  int          runQ [$];
  logic [5:0]  mFactor = '0;
  logic [7:0]  mHp = '0;
  logic        mLocked = 1'b0;
  logic        mValid = 1'b0;
  logic        mRerr = 1'b0;
  logic        mTout = 1'b0;
  logic        mPrevLocked = 1'b0;
  logic        mPrevRerr = 1'b0;
  logic        dPrevLocked = 1'b0;
  logic        dPrevRerr = 1'b0;

  clock_divide_measure #(
    .CNT_W      (CNT_W),
    .LOCK_COUNT (LOCK_COUNT),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sig_in      (sig_in),
    .meas_en     (meas_en),
    .factor_out  (factor_out),
    .half_period (half_period),
    .locked      (locked),
    .valid       (valid),
    .range_err   (range_err),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Model of the outputs after posedge p; e means an edge reaches the measurement logic.
  task automatic modelStep(input int p, input bit e, input bit en, input bit r);
    int  h;
    bit  ok;
    ev_t ev;
    mValid = 1'b0;
    mTout  = 1'b0;
    if (r) begin
      mPhase = 0; mFactor = '0; mHp = '0; mLocked = 1'b0; mRerr = 1'b0;
      runQ.delete();
    end else if (!en) begin
      mPhase = 0; mHp = '0; mLocked = 1'b0; mRerr = 1'b0;
      runQ.delete();
    end else if (mPhase == 0) begin
      mPhase = 1;
    end else if (mPhase == 1) begin
      if (e) begin
        mLast = p;
        mPhase = 2;
      end
    end else if (e) begin
      h = p - mLast;
      if (h > TIMEOUT) h = TIMEOUT;
      mLast = p;
      mHp = 8'(h);
      ok = (h >= 2) && (h <= 65);
      if (!ok) mRerr = 1'b1;
      if (mPhase == 3 && h == mLockedH) begin
        mValid = 1'b1;
      end else begin
        if (!ok) runQ.delete();
        else begin
          if (runQ.size() > 0 && runQ[$] != h) runQ.delete();
          runQ.push_back(h);
        end
        if (mPhase == 2 && runQ.size() >= LOCK_COUNT) begin
          mFactor = 6'(h - 2);
          mLocked = 1'b1;
          mLockedH = h;
          mPhase = 3;
        end else begin
          mLocked = 1'b0;
          mPhase = 2;
        end
      end
    end else if (p - mLast == TIMEOUT) begin
      mTout = 1'b1;
      mLocked = 1'b0;
      runQ.delete();
      mPhase = 1;
    end
    if (mValid || mTout || mLocked != mPrevLocked || mRerr != mPrevRerr) begin
      ev.cyc = p; ev.factor = mFactor; ev.hp = mHp; ev.locked = mLocked;
      ev.valid = mValid; ev.rerr = mRerr; ev.tout = mTout;
      expQ.push_back(ev);
    end
    mPrevLocked = mLocked;
    mPrevRerr = mRerr;
  endtask

  // One clock of stimulus; the input is driven on the falling edge.
  task automatic tick(input bit doTog, input bit en, input bit r);
    int c;
    bit e;
    @(negedge clk);
    c = cyc;
    if (c >= MAXC - 1) begin
      $display("[TB] FAIL cycle_budget: got cycle %0d, limit %0d", c, MAXC - 1);
      $fatal(1, "[TB] cycle budget exhausted");
    end
    if (r) begin
      sigV = 1'b0;
      for (int k = c - 3; k <= c; k++) if (k >= 0) togAt[k] = 1'b0;
    end else if (doTog) begin
      sigV = ~sigV;
      togAt[c] = 1'b1;
    end
    sig_in  = sigV;
    meas_en = en;
    rst     = r;
    e = (c >= 3) ? togAt[c-3] : 1'b0;
    modelStep(c + 1, e, en, r);
  endtask

  task automatic applyStimulus(input int spacing, input int nEdges);
    for (int i = 0; i < nEdges; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      for (int j = 1; j < spacing; j++) tick(1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic holdIdle(input int n, input bit en);
    for (int i = 0; i < n; i++) tick(1'b0, en, 1'b0);
  endtask

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Scoreboard monitor: every DUT output event must match the next predicted one.
  always @(negedge clk) begin
    ev_t ex;
    bit  dutEv;
    while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
      ex = expQ.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL missed_event: cycle %0d got no event, expected locked=%0d valid=%0d rerr=%0d tout=%0d",
               ex.cyc, ex.locked, ex.valid, ex.rerr, ex.tout);
    end
    dutEv = (valid === 1'b1) || (timeout === 1'b1) ||
            (locked !== dPrevLocked) || (range_err !== dPrevRerr);
    if (dutEv) begin
      checks++;
      if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
        ex = expQ.pop_front();
        if (factor_out !== ex.factor || half_period !== ex.hp || locked !== ex.locked ||
            valid !== ex.valid || range_err !== ex.rerr || timeout !== ex.tout) begin
          errors++;
          $display("[TB] FAIL event_cmp cycle %0d: got f=%0d hp=%0d l=%0d v=%0d re=%0d to=%0d, expected f=%0d hp=%0d l=%0d v=%0d re=%0d to=%0d",
                   cyc, factor_out, half_period, locked, valid, range_err, timeout,
                   ex.factor, ex.hp, ex.locked, ex.valid, ex.rerr, ex.tout);
        end
      end else begin
        errors++;
        $display("[TB] FAIL unexpected_event cycle %0d: got l=%0d v=%0d re=%0d to=%0d, expected no event",
                 cyc, locked, valid, range_err, timeout);
      end
    end
    dPrevLocked = locked;
    dPrevRerr = range_err;
  end

  initial begin
    int sp;
    int n;
    rst = 1'b1;
    meas_en = 1'b0;
    sig_in = 1'b0;
    repeat (3) tick(1'b0, 1'b0, 1'b1);
    checkOutput("reset_factor", int'(factor_out), 0);
    checkOutput("reset_half_period", int'(half_period), 0);
    checkOutput("reset_locked", int'(locked), 0);
    checkOutput("reset_valid", int'(valid), 0);
    checkOutput("reset_range_err", int'(range_err), 0);
    checkOutput("reset_timeout", int'(timeout), 0);
    holdIdle(2, 1'b0);

    $display("[TB] factor 5, then 0 and 63");
    applyStimulus(7, 9);
    checkOutput("lock_f5_locked", int'(locked), 1);
    checkOutput("lock_f5_factor", int'(factor_out), 5);
    applyStimulus(2, 8);
    applyStimulus(65, 7);
    checkOutput("lock_f63_factor", int'(factor_out), 63);
    checkOutput("lock_f63_rerr", int'(range_err), 0);

    $display("[TB] switch from factor 5 to factor 20");
    applyStimulus(7, 7);
    applyStimulus(22, 7);
    checkOutput("relock_f20_factor", int'(factor_out), 20);

    $display("[TB] out-of-range spacings");
    applyStimulus(1, 3);
    applyStimulus(70, 3);
    checkOutput("range_err_set", int'(range_err), 1);
    checkOutput("range_locked", int'(locked), 0);
    tick(1'b0, 1'b0, 1'b0);
    holdIdle(2, 1'b1);
    checkOutput("range_err_cleared", int'(range_err), 0);

    $display("[TB] timeout and recovery");
    applyStimulus(7, 8);
    holdIdle(300, 1'b1);
    applyStimulus(7, 8);

    $display("[TB] reset and meas_en drop while locked");
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    applyStimulus(9, 8);
    tick(1'b0, 1'b0, 1'b0);
    holdIdle(1, 1'b1);
    checkOutput("en_drop_factor_held", int'(factor_out), 7);
    applyStimulus(9, 8);

    $display("[TB] randomized segments");
    repeat (25) begin
      sp = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 80)) : int'($urandom_range(2, 30));
      n = $urandom_range(3, 9);
      applyStimulus(sp, n);
      if ($urandom_range(0, 9) == 0) begin
        tick(1'b0, 1'b0, 1'b0);
      end else if ($urandom_range(0, 14) == 0) begin
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
      end
    end

    holdIdle(10, 1'b1);
    @(negedge clk);
    while (expQ.size() > 0) begin
      ev_t ex;
      ex = expQ.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL leftover_event: cycle %0d never observed, expected locked=%0d valid=%0d",
               ex.cyc, ex.locked, ex.valid);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
